dqsw_wrlvl_trainer: RTL and testbench

//   Write-leveling training controller that drives the DQSW training IOD lane.

---
 rtl/dqsw_wrlvl_trainer.sv | 186 ++++++++++++++++++
 tb/tb_dqsw_wrlvl_trainer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dqsw_wrlvl_trainer.sv
// -----------------------------------------------------------------------------
// dqsw_wrlvl_trainer
//   Write-leveling training controller for the DQSW training IOD lane.
//   It sweeps the IOD delay line one tap at a time and fires one DQS pulse per
//   tap. For each tap it takes a majority vote over RX_DATA[0] and reports the
//   first tap whose vote is 1 after some earlier tap voted 0.
//
// Ports
//   FAB_CLK                 : clock; every register is clocked by it
//   ARST_N                  : asynchronous active-low reset
//   START                   : level; starts a sweep from IDLE, DONE or FAIL
//   ABORT                   : returns to IDLE and clears the status outputs
//   RX_DATA[1:0]            : DQ feedback from the IOD (only bit 0 is voted)
//   EYE_MONITOR_EARLY/LATE  : IOD eye-monitor flags, folded into EYE_FLAG
//   DELAY_LINE_OUT_OF_RANGE : IOD delay line has reached its end stop
//   TX_DATA/OE_DATA[1:0]    : DQS pattern and output enable to the IOD
//   DELAY_LINE_LOAD/MOVE    : one-cycle pulses that reload / step the delay line
//   DELAY_LINE_DIRECTION    : 1 (increment) while BUSY
//   EYE_MONITOR_CLEAR_FLAGS : one-cycle pulse at the start of each tap
//   BUSY                    : sweep in progress
//   TRAIN_DONE / TRAIN_ERR  : sticky result status
//   TAP_RESULT[TAP_W-1:0]   : winning tap index
//   EYE_FLAG                : sticky OR of EARLY|LATE seen while sampling
// -----------------------------------------------------------------------------
module dqsw_wrlvl_trainer #(
  parameter int MAX_TAPS      = 128,
  parameter int TAP_W         = 7,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       RX_DATA,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic [1:0]       TX_DATA,
  output logic [1:0]       OE_DATA,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_ERR,
  output logic [TAP_W-1:0] TAP_RESULT,
  output logic             EYE_FLAG
);

  localparam int CNT_W   = $clog2(SAMPLES + 1);
  localparam int TMR_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_PULSE, S_SETTLE,
    S_SAMPLE, S_EVAL, S_MOVE, S_DONE, S_FAIL
  } state_t;

  state_t             r_state, w_nxt;
  logic [TMR_W-1:0]   r_tmr;
  logic [CNT_W-1:0]   r_ones;
  logic [TAP_W-1:0]   r_tap;
  logic               r_seen_zero;
  logic               w_bit, w_entry;
  logic               w_load, w_move, w_clr, w_busy;
  logic [1:0]         w_tx, w_oe;
  logic               w_unused;

  // Only bit 0 of the feedback carries the DQ sample used for voting.
  assign w_unused = RX_DATA[1];

  // Strict majority: a tie votes 0.
  assign w_bit = ({r_ones, 1'b0} > (CNT_W + 1)'(SAMPLES));

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_load  = 1'b0;
    w_move  = 1'b0;
    w_clr   = 1'b0;
    w_tx    = 2'b00;
    w_oe    = 2'b00;
    w_busy  = 1'b1;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        w_busy = 1'b0;
        if (START) w_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_nxt  = S_CLEAR;
      end
      S_CLEAR: begin
        w_clr = 1'b1;
        w_nxt = S_PULSE;
      end
      S_PULSE: begin
        w_oe  = 2'b11;
        w_tx  = 2'b10;
        w_nxt = S_SETTLE;
      end
      S_SETTLE: if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) w_nxt = S_SAMPLE;
      S_SAMPLE: if (r_tmr == TMR_W'(SAMPLES - 1))       w_nxt = S_EVAL;
      S_EVAL: begin
        if (w_bit && r_seen_zero)                                   w_nxt = S_DONE;
        else if (r_tap == TAP_W'(MAX_TAPS - 1) || DELAY_LINE_OUT_OF_RANGE) w_nxt = S_FAIL;
        else                                                        w_nxt = S_MOVE;
      end
      S_MOVE: begin
        w_move = 1'b1;
        w_nxt  = S_CLEAR;
      end
      default: w_nxt = S_IDLE;
    endcase
    // Abort wins over everything, including START, and silences all pulses.
    if (ABORT) begin
      w_nxt  = S_IDLE;
      w_load = 1'b0;
      w_move = 1'b0;
      w_clr  = 1'b0;
      w_tx   = 2'b00;
      w_oe   = 2'b00;
      w_busy = 1'b0;
    end
  end

  // Only IDLE/DONE/FAIL can move to LOAD, so this marks a new sweep.
  assign w_entry = (w_nxt == S_LOAD);

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_tmr                   <= '0;
      r_ones                  <= '0;
      r_tap                   <= '0;
      r_seen_zero             <= 1'b0;
      TAP_RESULT              <= '0;
      TRAIN_DONE              <= 1'b0;
      TRAIN_ERR               <= 1'b0;
      EYE_FLAG                <= 1'b0;
      TX_DATA                 <= 2'b00;
      OE_DATA                 <= 2'b00;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      BUSY                    <= 1'b0;
    end else begin
      // Timer restarts whenever the state changes; it only matters in SETTLE/SAMPLE.
      r_tmr <= (w_nxt != r_state) ? '0 : r_tmr + 1'b1;

      if (r_state == S_CLEAR)       r_ones <= '0;
      else if (r_state == S_SAMPLE) r_ones <= r_ones + CNT_W'(RX_DATA[0]);

      if (w_entry)                  r_tap <= '0;
      else if (r_state == S_MOVE)   r_tap <= r_tap + 1'b1;

      if (w_entry)                          r_seen_zero <= 1'b0;
      else if (r_state == S_EVAL && !w_bit) r_seen_zero <= 1'b1;

      if (w_entry || w_nxt == S_FAIL)                   TAP_RESULT <= '0;
      else if (r_state == S_EVAL && w_nxt == S_DONE)    TAP_RESULT <= r_tap;

      // Status is asserted one cycle after entering DONE/FAIL and dropped on exit.
      TRAIN_DONE <= (r_state == S_DONE) && (w_nxt == S_DONE);
      TRAIN_ERR  <= (r_state == S_FAIL) && (w_nxt == S_FAIL);

      if (w_entry || ABORT)         EYE_FLAG <= 1'b0;
      else if (r_state == S_SAMPLE) EYE_FLAG <= EYE_FLAG | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;

      TX_DATA                 <= w_tx;
      OE_DATA                 <= w_oe;
      DELAY_LINE_LOAD         <= w_load;
      DELAY_LINE_MOVE         <= w_move;
      DELAY_LINE_DIRECTION    <= w_busy;
      EYE_MONITOR_CLEAR_FLAGS <= w_clr;
      BUSY                    <= w_busy;
    end
  end

endmodule

// File: tb/tb_dqsw_wrlvl_trainer.sv
// -----------------------------------------------------------------------------
// tb_dqsw_wrlvl_trainer
//   Directed bench for dqsw_wrlvl_trainer. The DQ feedback is generated from a
//   per-tap table of four samples, indexed by the cycle count since the START
//   sampling edge (16 cycles per tap, samples taken on phases 11..14).
// -----------------------------------------------------------------------------
module tb_dqsw_wrlvl_trainer;
  localparam int MAX_TAPS = 128;
  localparam int TAP_W    = 7;

  logic             FAB_CLK = 1'b0;
  logic             ARST_N, START, ABORT;
  logic [1:0]       RX_DATA;
  logic             EARLY, LATE, OOR;
  logic [1:0]       TX_DATA, OE_DATA;
  logic             LOAD, MOVE, DIR, CLR, BUSY, DONE, ERR, EYE;
  logic [TAP_W-1:0] TAP_RESULT;

  always #5 FAB_CLK = ~FAB_CLK;

  dqsw_wrlvl_trainer #(.MAX_TAPS(MAX_TAPS), .TAP_W(TAP_W), .SETTLE_CYCLES(8), .SAMPLES(4)) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .START(START), .ABORT(ABORT),
    .RX_DATA(RX_DATA), .EYE_MONITOR_EARLY(EARLY), .EYE_MONITOR_LATE(LATE),
    .DELAY_LINE_OUT_OF_RANGE(OOR), .TX_DATA(TX_DATA), .OE_DATA(OE_DATA),
    .DELAY_LINE_LOAD(LOAD), .DELAY_LINE_MOVE(MOVE), .DELAY_LINE_DIRECTION(DIR),
    .EYE_MONITOR_CLEAR_FLAGS(CLR), .BUSY(BUSY), .TRAIN_DONE(DONE), .TRAIN_ERR(ERR),
    .TAP_RESULT(TAP_RESULT), .EYE_FLAG(EYE)
  );

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int t0 = -100000;
  bit trk = 0;
  int mv, ld, pu, firstpu, bad, rel;
  logic [3:0] smp [MAX_TAPS];
  int oor_tap = -1;
  int late_tap = -1;
  bit early_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {13'd0, TX_DATA, OE_DATA, LOAD, MOVE, DIR, CLR, BUSY, DONE, ERR, EYE, TAP_RESULT};
  endfunction

  task automatic fill(input int lo, input int hi, input logic v);
    for (int t = lo; t <= hi; t++) smp[t] = {4{v}};
  endtask

  // One clock: observe outputs on the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    int n, tap, p, sidx;
    logic b;
    @(negedge FAB_CLK);
    ecnt++;
    if (trk) begin
      if (MOVE) mv++;
      if (LOAD) ld++;
      if (OE_DATA == 2'b11) begin
        pu++;
        if (firstpu < 0) firstpu = ecnt - t0;
        if (TX_DATA != 2'b10) bad++;
      end else if (OE_DATA != 2'b00 || TX_DATA != 2'b00) bad++;
      if (BUSY != DIR) bad++;
    end
    n = ecnt + 1 - t0;
    if (n >= 1) begin
      tap  = (n - 1) / 16;
      p    = (n - 1) % 16;
      if (tap > MAX_TAPS - 1) tap = MAX_TAPS - 1;
      sidx = p - 11;
      b    = (sidx >= 0 && sidx <= 3) ? smp[tap][sidx] : smp[tap][0];
      RX_DATA = {~b, b};
      OOR     = (oor_tap >= 0) && (tap >= oor_tap);
      EARLY   = early_mode && (p == 5);
      LATE    = (tap == late_tap) && (sidx == 2);
    end else begin
      RX_DATA = 2'b00;
      OOR = 1'b0; EARLY = 1'b0; LATE = 1'b0;
    end
  endtask

  task automatic start();
    mv = 0; ld = 0; pu = 0; firstpu = -1; bad = 0;
    t0 = ecnt + 1;
    trk = 1;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic run_to(input int r);
    while (ecnt - t0 < r) tick();
  endtask

  task automatic wait_end(input int bound, output int r);
    r = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (DONE || ERR) begin
        r = ecnt - t0;
        break;
      end
    end
    chk("end_reached", 32'(r >= 0), 32'd1);
  endtask

  initial begin
    ARST_N = 1'b0; START = 1'b0; ABORT = 1'b0;
    RX_DATA = 2'b00; EARLY = 1'b0; LATE = 1'b0; OOR = 1'b0;
    fill(0, MAX_TAPS - 1, 1'b0);
    repeat (3) tick();
    chk("rst_outs", outs_vec(), 32'd0);
    ARST_N = 1'b1;
    repeat (2) tick();
    chk("idle_outs", outs_vec(), 32'd0);

    // 0 on taps 0..9, 1 from tap 10: taps 0..9 each end in a MOVE, taps 0..10 each get a pulse.
    fill(0, 9, 1'b0); fill(10, MAX_TAPS - 1, 1'b1);
    start();
    wait_end(400, rel);
    chk("t1_cycle", rel, 177);
    chk("t1_tap", TAP_RESULT, 10);
    chk("t1_done", DONE, 1);
    chk("t1_err", ERR, 0);
    chk("t1_busy", BUSY, 0);
    chk("t1_moves", mv, 10);
    chk("t1_loads", ld, 1);
    chk("t1_pulses", pu, 11);
    chk("t1_first_pulse", firstpu, 3);
    chk("t1_bad_outs", bad, 0);
    chk("t1_eye", EYE, 0);
    repeat (5) tick();
    chk("t1_hold", {DONE, TAP_RESULT}, {1'b1, 7'd10});

    // Leading 1s ignored; EARLY outside the sampling window leaves EYE_FLAG clear.
    fill(0, 4, 1'b1); fill(5, 6, 1'b0); fill(7, MAX_TAPS - 1, 1'b1);
    early_mode = 1;
    start();
    chk("t2_entry_clear", {DONE, TAP_RESULT}, 32'd0);
    wait_end(300, rel);
    chk("t2_cycle", rel, 129);
    chk("t2_tap", TAP_RESULT, 7);
    chk("t2_eye", EYE, 0);
    chk("t2_moves", mv, 7);
    early_mode = 0;

    // Tap 1 samples 1,0,1,0 (tie -> 0); tap 2 samples 1,1,0,1 (-> 1). LATE pulses while sampling tap 1.
    fill(0, 0, 1'b1); smp[1] = 4'b0101; smp[2] = 4'b1011; fill(3, MAX_TAPS - 1, 1'b1);
    late_tap = 1;
    start();
    wait_end(200, rel);
    chk("t5_cycle", rel, 49);
    chk("t5_tap", TAP_RESULT, 2);
    chk("t5_done", DONE, 1);
    chk("t5_eye", EYE, 1);
    late_tap = -1;

    // Never a 1: the sweep runs out after 128 taps.
    fill(0, MAX_TAPS - 1, 1'b0);
    start();
    chk("t3_entry_clear", {DONE, EYE}, 32'd0);
    wait_end(2200, rel);
    chk("t3_cycle", rel, 2049);
    chk("t3_err", ERR, 1);
    chk("t3_done", DONE, 0);
    chk("t3_moves", mv, 127);
    chk("t3_pulses", pu, 128);
    chk("t3_busy", BUSY, 0);
    chk("t3_tap", TAP_RESULT, 0);

    // End stop reached at tap 20 with data 0.
    oor_tap = 20;
    start();
    chk("t4_entry_clear", ERR, 0);
    wait_end(600, rel);
    chk("t4_cycle", rel, 337);
    chk("t4_err", ERR, 1);
    chk("t4_moves", mv, 20);
    repeat (40) tick();
    chk("t4_moves_after", mv, 20);
    chk("t4_err_hold", ERR, 1);
    oor_tap = -1;

    // ABORT during SETTLE of tap 3, then restart; a START while busy is ignored.
    fill(0, 9, 1'b0); fill(10, MAX_TAPS - 1, 1'b1);
    start();
    run_to(53);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t6_abort_outs", outs_vec(), 32'd0);
    chk("t6_abort_moves", mv, 3);
    repeat (20) tick();
    chk("t6_abort_quiet", {mv[7:0], 7'd0, BUSY}, {8'd3, 7'd0, 1'b0});
    start();
    run_to(99);
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_end(400, rel);
    chk("t6_restart_cycle", rel, 177);
    chk("t6_restart_tap", TAP_RESULT, 10);
    chk("t6_restart_loads", ld, 1);
    chk("t6_restart_moves", mv, 10);

    // Asynchronous reset during SETTLE of tap 3, then restart.
    start();
    run_to(53);
    ARST_N = 1'b0;
    tick();
    chk("t6_rst_outs", outs_vec(), 32'd0);
    ARST_N = 1'b1;
    repeat (20) tick();
    chk("t6_rst_moves", mv, 3);
    chk("t6_rst_loads", ld, 1);
    chk("t6_rst_busy", BUSY, 0);
    start();
    wait_end(400, rel);
    chk("t6_rst_restart_cycle", rel, 177);
    chk("t6_rst_restart_tap", TAP_RESULT, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
